// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_bank divider bank.
package clk_div_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_CYW = 32;
    localparam int DEF_DIV = 10;

    typedef logic [DEF_DW-1:0]  div_t;
    typedef logic [DEF_CYW-1:0] cyc_t;

    typedef enum logic {
        CH_OFF,
        CH_RUN
    } ch_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divide values,
// divided level and rising-edge strobe.
module clk_div_chan #(
    parameter int DW      = 8,
    parameter int RST_DIV = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          accept,
    input  logic [DW-1:0] cfg_div,
    output logic          pending,
    output logic          div_clk,
    output logic          tick
);
    import clk_div_pkg::*;

    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0] div;
    logic [DW-1:0] cnt;
    logic [DW-1:0] pend_div;
    ch_state_e     state;
    logic          terminal;

    assign state    = (div == '0) ? CH_OFF : CH_RUN;
    assign terminal = (state == CH_RUN) && (cnt == div - ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= DW'(RST_DIV);
            cnt      <= '0;
            pend_div <= '0;
            pending  <= 1'b0;
            div_clk  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (accept) begin
                pending  <= 1'b1;
                pend_div <= cfg_div;
            end
            if (advance) begin
                if (state == CH_OFF) begin
                    cnt     <= '0;
                    div_clk <= 1'b0;
                    if (pending) begin
                        div     <= pend_div;
                        pending <= 1'b0;
                    end
                end else if (terminal) begin
                    cnt <= '0;
                    // A pending zero turns the channel off at its terminal, low.
                    if (pending && pend_div == '0) begin
                        div_clk <= 1'b0;
                    end else begin
                        div_clk <= ~div_clk;
                        tick    <= ~div_clk;
                    end
                    if (pending) begin
                        div     <= pend_div;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers sharing a cycle counter with limit stop.
// Optional CLK_DIV_BANK_DISPLAY_EN adds simulation-only tick/done messages.
module clk_div_bank #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int CYW     = 32,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH):0]   cfg_ch,
    input  logic [DW-1:0]          cfg_div,
    input  logic [CYW-1:0]         limit,
    output logic [NCH-1:0]         div_clk,
    output logic [NCH-1:0]         tick,
    output logic [CYW-1:0]         cycle,
    output logic                   done
);
    localparam int CHW = $clog2(NCH) + 1;

    logic           advance;
    logic [NCH-1:0] pending;
    logic [CYW-1:0] cycle_nxt;

    assign advance   = enable && !done;
    assign cfg_ready = ~|pending;
    assign cycle_nxt = advance ? cycle + CYW'(1) : cycle;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic accept;
            // Out-of-range channel indices match no channel and are dropped.
            assign accept = cfg_valid && cfg_ready && (cfg_ch == CHW'(gi));

            clk_div_chan #(
                .DW      (DW),
                .RST_DIV (DEF_DIV)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .advance (advance),
                .accept  (accept),
                .cfg_div (cfg_div),
                .pending (pending[gi]),
                .div_clk (div_clk[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle <= '0;
            done  <= 1'b0;
        end else begin
            cycle <= cycle_nxt;
            if (limit != '0 && cycle_nxt >= limit) begin
                done <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_BANK_DISPLAY_EN
    int unsigned tick_n [NCH];
    logic        done_q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) tick_n[i] = 0;
            done_q = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (tick[i]) begin
                    tick_n[i] = tick_n[i] + 1;
                    $display("[%0t] ch%0d tick %0d", $time, i, tick_n[i]);
                end
            end
            if (done && !done_q) $display("[%0t] done cycle=%0d", $time, cycle);
            done_q = done;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank, plus a CYW=4 instance for wrap/limit cases.
module tb_clk_div_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_ch = '0;
    logic [7:0]  cfg_div = '0;
    logic [31:0] limit = '0;
    logic [3:0]  div_clk;
    logic [3:0]  tick;
    logic [31:0] cycle;
    logic        done;

    logic        rst2 = 1'b1;
    logic        cfg_ready2;
    logic [3:0]  limit2 = '0;
    logic [3:0]  div_clk2;
    logic [3:0]  tick2;
    logic [3:0]  cycle2;
    logic        done2;

    int passed = 0;
    int total  = 0;

    clk_div_bank #(.NCH(4), .DW(8), .CYW(32), .DEF_DIV(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .limit     (limit),
        .div_clk   (div_clk),
        .tick      (tick),
        .cycle     (cycle),
        .done      (done)
    );

    clk_div_bank #(.NCH(4), .DW(8), .CYW(4), .DEF_DIV(10)) dut2 (
        .clk       (clk),
        .reset     (rst2),
        .enable    (1'b1),
        .cfg_valid (1'b0),
        .cfg_ready (cfg_ready2),
        .cfg_ch    (3'd0),
        .cfg_div   (8'd0),
        .limit     (limit2),
        .div_clk   (div_clk2),
        .tick      (tick2),
        .cycle     (cycle2),
        .done      (done2)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_cycle", 64'(cycle), 0);
        chk("rst_div_clk", 64'(div_clk), 0);
        chk("rst_tick", 64'(tick), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ready", 64'(cfg_ready), 1);
        #10 reset = 1'b0;

        // defaults: rise after 10th edge, period 20
        step(9);
        chk("t1_c9_div_clk", 64'(div_clk), 4'h0);
        step(1);
        chk("t1_c10_cycle", 64'(cycle), 10);
        chk("t1_c10_div_clk", 64'(div_clk), 4'hF);
        chk("t1_c10_tick", 64'(tick), 4'hF);
        step(1);
        chk("t1_c11_tick", 64'(tick), 4'h0);

        // ch1 -> div 3 requested at cycle 15
        step(4);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
        step(1);
        cfg_valid = 1'b0;
        chk("t2_c16_ready", 64'(cfg_ready), 0);
        step(3);
        chk("t2_c19_ready", 64'(cfg_ready), 0);
        chk("t2_c19_div_clk", 64'(div_clk), 4'hF);
        step(1);
        chk("t2_c20_div_clk", 64'(div_clk), 4'h0);
        step(3);
        chk("t2_c23_div_clk", 64'(div_clk), 4'b0010);
        chk("t2_c23_tick", 64'(tick), 4'b0010);
        chk("t2_c23_ready", 64'(cfg_ready), 1);
        step(3);
        chk("t2_c26_div_clk", 64'(div_clk), 4'b0000);
        step(3);
        chk("t2_c29_div_clk", 64'(div_clk), 4'b0010);
        step(1);
        chk("t2_c30_div_clk", 64'(div_clk), 4'b1111);
        chk("t2_c30_tick", 64'(tick), 4'b1101);

        // ch2 off while high, then div 1
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd0;
        step(1);
        cfg_valid = 1'b0;
        step(9);
        chk("t4_c40_div_clk", 64'(div_clk), 4'b0000);
        chk("t4_c40_ready", 64'(cfg_ready), 1);
        step(10);
        chk("t4_c50_div_clk", 64'(div_clk), 4'b1001);
        chk("t4_c50_tick", 64'(tick), 4'b1001);
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd1;
        step(1);
        cfg_valid = 1'b0;
        chk("t4_c51_ready", 64'(cfg_ready), 0);
        step(1);
        chk("t4_c52_ready", 64'(cfg_ready), 1);
        chk("t4_c52_ch2", 64'(div_clk[2]), 0);
        step(1);
        chk("t4_c53_div_clk", 64'(div_clk), 4'b1111);
        chk("t4_c53_tick", 64'(tick), 4'b0110);
        step(1);
        chk("t4_c54_div_clk", 64'(div_clk), 4'b1011);
        chk("t4_c54_tick", 64'(tick), 4'b0000);
        step(1);
        chk("t4_c55_tick", 64'(tick), 4'b0100);

        // enable low for 5 cycles
        enable = 1'b0;
        step(5);
        chk("t5_hold_cycle", 64'(cycle), 55);
        chk("t5_hold_div_clk", 64'(div_clk), 4'b1111);
        chk("t5_hold_tick", 64'(tick), 4'b0000);
        enable = 1'b1;
        step(1);
        chk("t5_c56_cycle", 64'(cycle), 56);
        chk("t5_c56_div_clk", 64'(div_clk), 4'b1001);

        // out-of-range channel
        cfg_valid = 1'b1; cfg_ch = 3'd4; cfg_div = 8'd7;
        step(1);
        cfg_valid = 1'b0;
        chk("t6_c57_ready", 64'(cfg_ready), 1);
        chk("t6_c57_div_clk", 64'(div_clk), 4'b1101);
        step(3);
        chk("t6_c60_div_clk", 64'(div_clk), 4'b0010);
        chk("t6_c60_cycle", 64'(cycle), 60);

        // async reset mid-run
        #2 reset = 1'b1;
        #1;
        chk("t5_arst_cycle", 64'(cycle), 0);
        chk("t5_arst_div_clk", 64'(div_clk), 0);
        chk("t5_arst_tick", 64'(tick), 0);
        chk("t5_arst_ready", 64'(cfg_ready), 1);

        // limit 2000
        limit = 32'd2000;
        step(1);
        #2 reset = 1'b0;
        step(1990);
        chk("t3_c1990_div_clk", 64'(div_clk), 4'hF);
        chk("t3_c1990_tick", 64'(tick), 4'hF);
        step(9);
        chk("t3_c1999_done", 64'(done), 0);
        step(1);
        chk("t3_c2000_cycle", 64'(cycle), 2000);
        chk("t3_c2000_done", 64'(done), 1);
        chk("t3_c2000_div_clk", 64'(div_clk), 4'h0);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3;
        step(1);
        cfg_valid = 1'b0;
        chk("t3_frozen_ready", 64'(cfg_ready), 0);
        step(5);
        chk("t3_frozen_cycle", 64'(cycle), 2000);
        chk("t3_frozen_div_clk", 64'(div_clk), 4'h0);
        chk("t3_frozen_tick", 64'(tick), 4'h0);
        chk("t3_frozen_done", 64'(done), 1);

        // CYW=4 wrap and limit lowered below cycle
        #2 rst2 = 1'b0;
        step(15);
        chk("w_c15_cycle", 64'(cycle2), 15);
        step(1);
        chk("w_wrap_cycle", 64'(cycle2), 0);
        chk("w_wrap_done", 64'(done2), 0);
        step(5);
        chk("w_c5_cycle", 64'(cycle2), 5);
        limit2 = 4'd3;
        step(1);
        chk("w_low_cycle", 64'(cycle2), 6);
        chk("w_low_done", 64'(done2), 1);
        step(2);
        chk("w_low_hold", 64'(cycle2), 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
